// File: rtl/z80_dma_bus_arbiter.sv
// BUSRQ/BUSAK arbiter sharing the tv80s memory/IO bus with one DMA master.
// Bounds DMA hold time and guarantees a CPU-ownership window between grants.
module z80_dma_bus_arbiter #(
    parameter int unsigned MAX_HOLD = 100,
    parameter int unsigned MIN_CPU  = 4,
    parameter int unsigned CNT_W    = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       dma_req,
    output logic       dma_gnt,
    output logic       cpu_busrq_n,
    input  logic       cpu_busak_n,
    output logic       bus_sel,
    output logic       hold_expired,
    output logic [7:0] grant_count
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_GRANT,
        ST_RELEASE,
        ST_COOLDOWN
    } state_t;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);
    localparam logic [CNT_W-1:0] COOL_INIT = CNT_W'(MIN_CPU);

    state_t           state, state_nx;
    logic [CNT_W-1:0] hold_cnt, hold_nx;
    logic [CNT_W-1:0] cool_cnt, cool_nx;
    logic             gnt_nx, busrq_n_nx, sel_nx, exp_nx;
    logic [7:0]       gc_nx;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= ST_IDLE;
            hold_cnt     <= '0;
            cool_cnt     <= '0;
            dma_gnt      <= 1'b0;
            cpu_busrq_n  <= 1'b1;
            bus_sel      <= 1'b0;
            hold_expired <= 1'b0;
            grant_count  <= '0;
        end else begin
            state        <= state_nx;
            hold_cnt     <= hold_nx;
            cool_cnt     <= cool_nx;
            dma_gnt      <= gnt_nx;
            cpu_busrq_n  <= busrq_n_nx;
            bus_sel      <= sel_nx;
            hold_expired <= exp_nx;
            grant_count  <= gc_nx;
        end
    end

    always_comb begin
        state_nx = state;
        hold_nx  = hold_cnt;
        cool_nx  = cool_cnt;
        exp_nx   = 1'b0;
        gc_nx    = grant_count;
        case (state)
            ST_IDLE: begin
                if (dma_req) state_nx = ST_REQ;
            end
            ST_REQ: begin
                // An abort wins over a simultaneous ack: no grant is ever issued.
                if (!dma_req) begin
                    state_nx = ST_RELEASE;
                end else if (!cpu_busak_n) begin
                    state_nx = ST_GRANT;
                    hold_nx  = '0;
                end
            end
            ST_GRANT: begin
                if ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST)) begin
                    state_nx = ST_RELEASE;
                    exp_nx   = 1'b1;
                    gc_nx    = grant_count + 8'd1;
                end else if (!dma_req) begin
                    state_nx = ST_RELEASE;
                    gc_nx    = grant_count + 8'd1;
                end else begin
                    hold_nx = hold_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (cpu_busak_n) begin
                    state_nx = ST_COOLDOWN;
                    cool_nx  = COOL_INIT;
                end
            end
            ST_COOLDOWN: begin
                if (cool_cnt == '0) state_nx = ST_IDLE;
                else                cool_nx  = cool_cnt - CNT_W'(1);
            end
            default: state_nx = ST_IDLE;
        endcase

        // Outputs are decoded from the next state so they register alongside it.
        gnt_nx     = (state_nx == ST_GRANT);
        busrq_n_nx = !((state_nx == ST_REQ) || (state_nx == ST_GRANT));
        sel_nx     = (state_nx == ST_GRANT) || (state_nx == ST_RELEASE);
    end

endmodule

// File: tb/tb_z80_dma_bus_arbiter.sv
// Bench for z80_dma_bus_arbiter: two instances (bounded and unlimited hold) driven by a
// BUSRQ/BUSAK CPU stand-in and checked every cycle against an ownership-level model.
module tb_z80_dma_bus_arbiter;

    localparam int MAXH1 = 100;
    localparam int MINC1 = 4;
    localparam int MAXH0 = 0;
    localparam int MINC0 = 0;

    logic clk = 1'b0;
    logic rst_n;
    logic req1, req0;
    logic gnt1, busrq1_n, sel1, hexp1;
    logic gnt0, busrq0_n, sel0, hexp0;
    logic busak1_n = 1'b1;
    logic busak0_n = 1'b1;
    logic [7:0] gc1, gc0;
    int ak_dly1, ak_dly0, ak_cnt1, ak_cnt0;
    bit glitch1;
    logic wr;
    logic [7:0] mem [0:65535];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    z80_dma_bus_arbiter #(.MAX_HOLD(MAXH1), .MIN_CPU(MINC1), .CNT_W(16)) dut1 (
        .clk(clk), .reset_n(rst_n), .dma_req(req1), .dma_gnt(gnt1),
        .cpu_busrq_n(busrq1_n), .cpu_busak_n(busak1_n), .bus_sel(sel1),
        .hold_expired(hexp1), .grant_count(gc1)
    );

    z80_dma_bus_arbiter #(.MAX_HOLD(MAXH0), .MIN_CPU(MINC0), .CNT_W(16)) dut0 (
        .clk(clk), .reset_n(rst_n), .dma_req(req0), .dma_gnt(gnt0),
        .cpu_busrq_n(busrq0_n), .cpu_busak_n(busak0_n), .bus_sel(sel0),
        .hold_expired(hexp0), .grant_count(gc0)
    );

    // CPU stand-in: floats the bus ak_dly cycles after busrq_n falls, reclaims it next cycle.
    always @(posedge clk) begin
        if (busrq1_n) begin
            busak1_n <= 1'b1;
            ak_cnt1  <= 0;
        end else if (ak_cnt1 >= ak_dly1) begin
            busak1_n <= glitch1 && !busak1_n && ($urandom_range(0, 7) == 0);
        end else begin
            ak_cnt1 <= ak_cnt1 + 1;
        end
        if (busrq0_n) begin
            busak0_n <= 1'b1;
            ak_cnt0  <= 0;
        end else if (ak_cnt0 >= ak_dly0) begin
            busak0_n <= 1'b0;
        end else begin
            ak_cnt0 <= ak_cnt0 + 1;
        end
    end

    always @(posedge clk) begin
        if (wr && gnt1 && sel1) mem[16'h8000] <= 8'hA5;
    end

    typedef struct {
        bit asking;
        bit granted;
        bit draining;
        int cool;
        int held;
        int grants;
        bit expired;
    } mdl_t;

    function automatic mdl_t mdl_reset();
        mdl_t m;
        m.asking = 0; m.granted = 0; m.draining = 0;
        m.cool = -1; m.held = 0; m.grants = 0; m.expired = 0;
        return m;
    endfunction

    function automatic mdl_t mdl_step(mdl_t m, bit req, bit ak_n, int maxh, int minc);
        mdl_t n = m;
        bit timeout;
        n.expired = 0;
        if (m.cool >= 0) begin
            n.cool = (m.cool == 0) ? -1 : m.cool - 1;
        end else if (m.draining) begin
            if (ak_n) begin
                n.draining = 0;
                n.cool     = minc;
            end
        end else if (m.granted) begin
            timeout = (maxh != 0) && (m.held + 1 == maxh);
            if (timeout || !req) begin
                n.granted  = 0;
                n.draining = 1;
                n.grants   = (m.grants + 1) % 256;
                n.expired  = timeout;
            end else begin
                n.held = m.held + 1;
            end
        end else if (m.asking) begin
            if (!req) begin
                n.asking   = 0;
                n.draining = 1;
            end else if (!ak_n) begin
                n.asking  = 0;
                n.granted = 1;
                n.held    = 0;
            end
        end else if (req) begin
            n.asking = 1;
        end
        return n;
    endfunction

    mdl_t m1, m0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m1 <= mdl_reset();
            m0 <= mdl_reset();
        end else begin
            m1 <= mdl_step(m1, req1, busak1_n, MAXH1, MINC1);
            m0 <= mdl_step(m0, req0, busak0_n, MAXH0, MINC0);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cmp_all();
        chk("gnt1",   32'(gnt1),     32'(m1.granted));
        chk("busrq1", 32'(busrq1_n), 32'(!(m1.asking || m1.granted)));
        chk("sel1",   32'(sel1),     32'(m1.granted || m1.draining));
        chk("exp1",   32'(hexp1),    32'(m1.expired));
        chk("gc1",    32'(gc1),      32'(m1.grants));
        chk("gnt0",   32'(gnt0),     32'(m0.granted));
        chk("busrq0", 32'(busrq0_n), 32'(!(m0.asking || m0.granted)));
        chk("sel0",   32'(sel0),     32'(m0.granted || m0.draining));
        chk("exp0",   32'(hexp0),    32'(m0.expired));
        chk("gc0",    32'(gc0),      32'(m0.grants));
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_all();
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_gnt"},   32'(gnt1),     32'd0);
        chk({tag, "_busrq"}, 32'(busrq1_n), 32'd1);
        chk({tag, "_sel"},   32'(sel1),     32'd0);
        chk({tag, "_exp"},   32'(hexp1),    32'd0);
        chk({tag, "_gc"},    32'(gc1),      32'd0);
    endtask

    initial begin
        int cnt, free, first, gcnt;
        bit seen;
        logic [7:0] gc_before;

        rst_n = 1'b0; req1 = 1'b0; req0 = 1'b0; wr = 1'b0;
        ak_dly1 = 1; ak_dly0 = 1; glitch1 = 0;
        mem[16'h8000] = 8'h00;

        // Reset held for three cycles.
        repeat (3) tick();
        chk_reset_vals("rst");
        rst_n = 1'b1;

        // Basic grant: request at cycle 10, DMA writes 0xA5 and holds 20 cycles.
        repeat (6) tick();
        req1 = 1'b1;
        tick();
        chk("busrq_latency", 32'(busrq1_n), 32'd0);
        for (int i = 0; i < 20 && !gnt1; i++) tick();
        chk("basic_gnt_seen", 32'(gnt1), 32'd1);
        wr = 1'b1;
        tick();
        wr = 1'b0;
        repeat (19) tick();
        req1 = 1'b0;
        tick();
        chk("basic_gnt_drop", 32'(gnt1), 32'd0);
        for (int i = 0; i < 20 && sel1; i++) tick();
        for (int i = 0; i < 4; i++) begin
            chk("basic_cpu_win", {30'd0, sel1, busrq1_n}, 32'b01);
            tick();
        end
        chk("basic_mem", 32'(mem[16'h8000]), 32'hA5);
        chk("basic_gc", 32'(gc1), 32'd1);

        // Timeout: request held continuously.
        req1 = 1'b1;
        for (int i = 0; i < 30 && !gnt1; i++) tick();
        cnt = 0;
        while (gnt1 && cnt < 200) begin
            cnt++;
            tick();
        end
        chk("hold_len", 32'(cnt), 32'd100);
        chk("hold_exp_pulse", 32'(hexp1), 32'd1);
        chk("hold_gc1", 32'(gc1), 32'd2);
        tick();
        chk("hold_exp_clear", 32'(hexp1), 32'd0);
        free = 0;
        for (int i = 0; i < 40 && busrq1_n; i++) begin
            if (!sel1) free++;
            tick();
        end
        chk("cpu_free_min", 32'(free >= MINC1), 32'd1);
        for (int i = 0; i < 30 && !gnt1; i++) tick();
        for (int i = 0; i < 200 && gnt1; i++) tick();
        chk("hold_gc2", 32'(gc1), 32'd3);
        req1 = 1'b0;
        repeat (20) tick();

        // Abort before the CPU acknowledges.
        ak_dly1 = 50;
        gc_before = gc1;
        req1 = 1'b1;
        tick();
        tick();
        req1 = 1'b0;
        seen = 0;
        repeat (30) begin
            tick();
            if (gnt1) seen = 1;
        end
        chk("abort_no_gnt", 32'(seen), 32'd0);
        chk("abort_busrq", 32'(busrq1_n), 32'd1);
        chk("abort_gc", 32'(gc1), 32'(gc_before));
        ak_dly1 = 1;

        // Randomised sharing with ack latency variation and busak glitches during grants.
        glitch1 = 1;
        repeat (400) begin
            if ($urandom_range(0, 9) == 0) req1 = ~req1;
            if ($urandom_range(0, 49) == 0) ak_dly1 = $urandom_range(0, 3);
            tick();
        end
        req1 = 1'b0;
        glitch1 = 0;
        repeat (30) tick();

        // Asynchronous reset in the middle of a grant.
        req1 = 1'b1;
        for (int i = 0; i < 30 && !gnt1; i++) tick();
        repeat (3) tick();
        chk("midrst_pre_gnt", 32'(gnt1), 32'd1);
        #2 rst_n = 1'b0;
        #1 chk_reset_vals("midrst");
        tick();
        req1 = 1'b0;
        rst_n = 1'b1;
        repeat (10) tick();

        // Unlimited hold, no cooldown: 500-cycle request on the second instance.
        req0 = 1'b1;
        first = -1; gcnt = 0; seen = 0;
        for (int i = 0; i < 500; i++) begin
            tick();
            if (gnt0) begin
                gcnt++;
                if (first < 0) first = i;
            end
            if (hexp0) seen = 1;
        end
        req0 = 1'b0;
        chk("unl_no_expire", 32'(seen), 32'd0);
        chk("unl_gnt_len", 32'(gcnt), 32'(500 - first));
        for (int i = 0; i < 20 && sel0; i++) tick();
        chk("unl_sel_back", 32'(sel0), 32'd0);
        chk("unl_gc", 32'(gc0), 32'd1);
        repeat (5) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
